// File: rtl/conv_encoder_stream.sv
`default_nettype none
// ============================================================================
// Module   : conv_encoder_stream
// Brief    : Frame-based streaming convolutional encoder with runtime K and
//            rate 1/2 or 1/3, valid/ready on both sides and zero-tail flush.
// Revision : 1.0 - initial release
// ============================================================================
module conv_encoder_stream #(
  parameter int MAX_K    = 9,
  parameter int MAX_RATE = 3,
  parameter int KW       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [KW-1:0]             i_cfg_k,
  input  logic                      i_cfg_rate,
  input  logic [MAX_RATE*MAX_K-1:0] i_gen_poly,
  input  logic                      i_start,
  input  logic                      i_bit,
  input  logic                      i_valid,
  input  logic                      i_last,
  output logic                      o_ready,
  output logic [MAX_RATE-1:0]       o_sym,
  output logic                      o_sym_valid,
  output logic                      o_sym_tail,
  input  logic                      i_sym_ready,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err
);

  localparam int SRW = MAX_K - 1;
  localparam int PW  = MAX_RATE * MAX_K;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_FLUSH = 2'd2,
    S_DRAIN = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [SRW-1:0]        sr_q, sr_d;
  logic [KW-1:0]         k_q, k_d;
  logic [KW-1:0]         tail_cnt_q, tail_cnt_d;
  logic                  rate_q, rate_d;
  logic [PW-1:0]         poly_q, poly_d;
  logic [MAX_RATE-1:0]   sym_q, sym_d;
  logic                  sym_valid_q, sym_valid_d;
  logic                  sym_tail_q, sym_tail_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic                  load_ok;
  logic                  accept;
  logic                  k_legal;
  logic                  enc_bit;
  logic [MAX_K-1:0]      tap_mask;
  logic [MAX_K-1:0]      enc_vec;
  logic [MAX_RATE-1:0]   enc_sym;

  // The output register may load when it is empty or being emptied this cycle.
  assign load_ok = !sym_valid_q || i_sym_ready;
  assign accept  = (state_q == S_RUN) && i_valid && load_ok;
  assign k_legal = (i_cfg_k >= KW'(3)) && (i_cfg_k <= KW'(MAX_K));
  assign enc_bit = (state_q == S_RUN) ? i_bit : 1'b0;
  assign enc_vec = {sr_q, enc_bit};

  always_comb begin
    tap_mask = '0;
    for (int i = 0; i < MAX_K; i++) begin
      tap_mask[i] = (i < int'(k_q));
    end
  end

  // Third polynomial only contributes at rate 1/3.
  always_comb begin
    enc_sym = '0;
    for (int j = 0; j < MAX_RATE; j++) begin
      if (j < 2 || (j == 2 && rate_q)) begin
        enc_sym[j] = ^(enc_vec & tap_mask & poly_q[j*MAX_K +: MAX_K]);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    sr_d        = sr_q;
    k_d         = k_q;
    rate_d      = rate_q;
    poly_d      = poly_q;
    tail_cnt_d  = tail_cnt_q;
    sym_d       = sym_q;
    sym_valid_d = sym_valid_q;
    sym_tail_d  = sym_tail_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    if (sym_valid_q && i_sym_ready) begin
      sym_valid_d = 1'b0;
      sym_tail_d  = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          if (k_legal) begin
            k_d        = i_cfg_k;
            rate_d     = i_cfg_rate;
            poly_d     = i_gen_poly;
            sr_d       = '0;
            tail_cnt_d = '0;
            state_d    = S_RUN;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      S_RUN: begin
        if (accept) begin
          sym_d       = enc_sym;
          sym_valid_d = 1'b1;
          sym_tail_d  = 1'b0;
          sr_d        = {sr_q[SRW-2:0], enc_bit};
          if (i_last) begin
            state_d    = S_FLUSH;
            tail_cnt_d = k_q - KW'(1);
          end
        end
      end
      S_FLUSH: begin
        if (load_ok) begin
          sym_d       = enc_sym;
          sym_valid_d = 1'b1;
          sym_tail_d  = 1'b1;
          sr_d        = {sr_q[SRW-2:0], enc_bit};
          tail_cnt_d  = (tail_cnt_q != '0) ? tail_cnt_q - KW'(1) : '0;
          if (tail_cnt_q <= KW'(1)) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (sym_valid_q && i_sym_ready) begin
          done_d  = 1'b1;
          sr_d    = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      sr_q        <= '0;
      k_q         <= '0;
      rate_q      <= 1'b0;
      poly_q      <= '0;
      tail_cnt_q  <= '0;
      sym_q       <= '0;
      sym_valid_q <= 1'b0;
      sym_tail_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sr_q        <= sr_d;
      k_q         <= k_d;
      rate_q      <= rate_d;
      poly_q      <= poly_d;
      tail_cnt_q  <= tail_cnt_d;
      sym_q       <= sym_d;
      sym_valid_q <= sym_valid_d;
      sym_tail_q  <= sym_tail_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign o_ready     = (state_q == S_RUN) && load_ok;
  assign o_sym       = sym_q;
  assign o_sym_valid = sym_valid_q;
  assign o_sym_tail  = sym_tail_q;
  assign o_busy      = (state_q != S_IDLE);
  assign o_done      = done_q;
  assign o_err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_stream.sv
`default_nettype none
// ============================================================================
// Module   : tb_conv_encoder_stream
// Brief    : Self-checking bench for conv_encoder_stream (vector table plus
//            scoreboard of expected {tail, symbol} per output handshake).
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv_encoder_stream;

  localparam int MAX_K    = 9;
  localparam int MAX_RATE = 3;
  localparam int KW       = 4;

  logic                      clk = 1'b0;
  logic                      rst = 1'b1;
  logic [KW-1:0]             i_cfg_k = '0;
  logic                      i_cfg_rate = 1'b0;
  logic [MAX_RATE*MAX_K-1:0] i_gen_poly = '0;
  logic                      i_start = 1'b0;
  logic                      i_bit = 1'b0;
  logic                      i_valid = 1'b0;
  logic                      i_last = 1'b0;
  logic                      o_ready;
  logic [MAX_RATE-1:0]       o_sym;
  logic                      o_sym_valid;
  logic                      o_sym_tail;
  logic                      i_sym_ready = 1'b1;
  logic                      o_busy;
  logic                      o_done;
  logic                      o_err;

  conv_encoder_stream #(.MAX_K(MAX_K), .MAX_RATE(MAX_RATE), .KW(KW)) dut (
    .clk(clk), .rst(rst), .i_cfg_k(i_cfg_k), .i_cfg_rate(i_cfg_rate),
    .i_gen_poly(i_gen_poly), .i_start(i_start), .i_bit(i_bit),
    .i_valid(i_valid), .i_last(i_last), .o_ready(o_ready), .o_sym(o_sym),
    .o_sym_valid(o_sym_valid), .o_sym_tail(o_sym_tail),
    .i_sym_ready(i_sym_ready), .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  k;
    logic        rate;
    logic [8:0]  p0, p1, p2;
    int          nbits;
    logic [63:0] bits;
    int          nsym;
    logic [23:0] syms;
    logic [7:0]  tail;
    int          rmode;
  } vec_t;

  int         checks = 0;
  int         errors = 0;
  logic [3:0] exp_q[$];
  logic [3:0] exp_e;
  int         hs_cnt = 0;
  int         done_cnt = 0;
  bit         done_due = 1'b0;
  int         ready_mode = 0;
  int         rcnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Downstream ready: always, 1-0-0 pattern, or random.
  always @(posedge clk) begin
    #1;
    rcnt++;
    case (ready_mode)
      0:       i_sym_ready = 1'b1;
      1:       i_sym_ready = (rcnt % 3 == 0);
      default: i_sym_ready = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    if (rst) begin
      done_due = 1'b0;
    end else begin
      if (o_done || done_due) chk("done_pulse", 32'(o_done), 32'(done_due));
      if (o_done) done_cnt++;
      done_due = 1'b0;
      if (o_sym_valid && !i_sym_ready) chk("ready_low_on_hold", 32'(o_ready), 32'd0);
      if (o_sym_valid && i_sym_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_sym actual=%0h required=none", {o_sym_tail, o_sym});
        end else begin
          exp_e = exp_q.pop_front();
          chk("sym", 32'({o_sym_tail, o_sym}), 32'(exp_e));
          if (exp_q.size() == 0) done_due = 1'b1;
        end
      end
    end
  end

  task automatic push_model(input logic [3:0] k, input logic rate, input logic [8:0] p0,
                            input logic [8:0] p1, input logic [8:0] p2, input int nbits,
                            input logic [63:0] bits);
    logic [2:0] s;
    logic [8:0] p;
    for (int n = 0; n < nbits + int'(k) - 1; n++) begin
      s = '0;
      for (int j = 0; j < 3; j++) begin
        p = (j == 0) ? p0 : (j == 1) ? p1 : p2;
        if (j < 2 || rate) begin
          for (int kk = 0; kk < int'(k); kk++) begin
            if (n - kk >= 0 && n - kk < nbits) s[j] = s[j] ^ (bits[n-kk] & p[kk]);
          end
        end
      end
      exp_q.push_back({(n >= nbits) ? 1'b1 : 1'b0, s});
    end
  endtask

  task automatic push_vec(input vec_t v);
    logic [23:0] sy;
    sy = v.syms;
    for (int i = 0; i < v.nsym; i++) exp_q.push_back({v.tail[i], sy[3*i +: 3]});
  endtask

  task automatic send_bit(input logic b, input logic last);
    int g;
    bit acc;
    g = 0;
    acc = 1'b0;
    i_valid = 1'b1;
    i_bit = b;
    i_last = last;
    while (!acc && g < 200) begin
      @(negedge clk);
      acc = o_ready;
      @(posedge clk);
      #1;
      g++;
    end
    if (!acc) chk("bit_accept_timeout", 32'd0, 32'd1);
    i_valid = 1'b0;
    i_last = 1'b0;
    i_bit = 1'($urandom);
  endtask

  task automatic start_frame(input logic [3:0] k, input logic rate, input logic [8:0] p0,
                             input logic [8:0] p1, input logic [8:0] p2);
    @(posedge clk);
    #1;
    i_cfg_k = k;
    i_cfg_rate = rate;
    i_gen_poly = {p2, p1, p0};
    i_start = 1'b1;
    @(posedge clk);
    #1;
    // A start while running is ignored, and config changes have no effect.
    i_cfg_k = 4'd15;
    i_cfg_rate = ~rate;
    i_gen_poly = 27'($urandom);
    @(negedge clk);
    chk("busy_run", 32'(o_busy), 32'd1);
    @(posedge clk);
    #1;
    i_start = 1'b0;
    @(negedge clk);
    chk("no_err_when_busy", 32'(o_err), 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic run_frame(input logic [3:0] k, input logic rate, input logic [8:0] p0,
                           input logic [8:0] p1, input logic [8:0] p2, input int nbits,
                           input logic [63:0] bits);
    int start_done;
    int guard;
    start_done = done_cnt;
    start_frame(k, rate, p0, p1, p2);
    for (int i = 0; i < nbits; i++) send_bit(bits[i], (i == nbits - 1));
    for (guard = 0; guard < 2000 && done_cnt == start_done; guard++) begin
      @(negedge clk);
      #1;
    end
    chk("frame_done", 32'(done_cnt - start_done), 32'd1);
    chk("busy_after_done", 32'(o_busy), 32'd0);
    chk("queue_empty", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  task automatic check_reset_outputs();
    chk("rst_sym_valid", 32'(o_sym_valid), 32'd0);
    chk("rst_sym", 32'(o_sym), 32'd0);
    chk("rst_sym_tail", 32'(o_sym_tail), 32'd0);
    chk("rst_ready", 32'(o_ready), 32'd0);
    chk("rst_busy", 32'(o_busy), 32'd0);
    chk("rst_done", 32'(o_done), 32'd0);
    chk("rst_err", 32'(o_err), 32'd0);
  endtask

  initial begin
    vec_t vecs[4];
    logic [3:0] bad_k[2];
    logic [63:0] rb;
    logic [8:0] q0, q1, q2;
    int base, guard, dcnt;

    // T1: K=3 rate 1/2 polys 7,5; bits 1,0,1,1.
    vecs[0] = '{k: 4'd3, rate: 1'b0, p0: 9'o7, p1: 9'o5, p2: 9'o7, nbits: 4,
                bits: 64'b1101, nsym: 6,
                syms: {6'b0, 3'b011, 3'b010, 3'b010, 3'b000, 3'b001, 3'b011},
                tail: 8'b0011_0000, rmode: 0};
    // T2: K=3 rate 1/3 polys 7,7,5; single bit 1.
    vecs[1] = '{k: 4'd3, rate: 1'b1, p0: 9'o7, p1: 9'o7, p2: 9'o5, nbits: 1,
                bits: 64'b1, nsym: 3,
                syms: {15'b0, 3'b111, 3'b011, 3'b111},
                tail: 8'b0000_0110, rmode: 0};
    // T3: T1 under back-pressure.
    vecs[2] = vecs[0];
    vecs[2].rmode = 1;
    // T4: T1 with high taps set in every poly.
    vecs[3] = vecs[0];
    vecs[3].p0 = 9'h1FF;
    vecs[3].p1 = 9'h1FD;
    vecs[3].p2 = 9'h1FF;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk);
    #1;
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      ready_mode = vecs[i].rmode;
      push_vec(vecs[i]);
      run_frame(vecs[i].k, vecs[i].rate, vecs[i].p0, vecs[i].p1, vecs[i].p2,
                vecs[i].nbits, vecs[i].bits);
    end
    ready_mode = 0;

    // T5: illegal K values are rejected with a one-cycle error pulse.
    bad_k[0] = 4'd2;
    bad_k[1] = 4'd10;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      i_cfg_k = bad_k[i];
      i_start = 1'b1;
      @(posedge clk);
      #1;
      i_start = 1'b0;
      @(negedge clk);
      chk("err_pulse", 32'(o_err), 32'd1);
      chk("err_busy", 32'(o_busy), 32'd0);
      chk("err_no_sym", 32'(o_sym_valid), 32'd0);
      @(negedge clk);
      chk("err_one_cycle", 32'(o_err), 32'd0);
      chk("err_still_idle", 32'(o_busy), 32'd0);
    end

    // T6: reset after the second symbol, then rerun T1.
    dcnt = done_cnt;
    push_vec(vecs[0]);
    start_frame(vecs[0].k, vecs[0].rate, vecs[0].p0, vecs[0].p1, vecs[0].p2);
    base = hs_cnt;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    for (guard = 0; guard < 50 && hs_cnt < base + 2; guard++) begin
      @(negedge clk);
      #1;
    end
    chk("abort_two_syms", 32'(hs_cnt - base), 32'd2);
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check_reset_outputs();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("no_done_aborted", 32'(done_cnt - dcnt), 32'd0);
    chk("idle_after_abort", 32'(o_busy), 32'd0);
    push_vec(vecs[0]);
    run_frame(vecs[0].k, vecs[0].rate, vecs[0].p0, vecs[0].p1, vecs[0].p2,
              vecs[0].nbits, vecs[0].bits);

    // Longer frames at other K and rates under random back-pressure.
    ready_mode = 2;
    for (int f = 0; f < 4; f++) begin
      rb = {$urandom, $urandom};
      q0 = 9'($urandom);
      q1 = 9'($urandom);
      q2 = 9'($urandom);
      push_model(4'(3 + 2 * f), 1'(f), q0, q1, q2, 10 + 7 * f, rb);
      run_frame(4'(3 + 2 * f), 1'(f), q0, q1, q2, 10 + 7 * f, rb);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
